instr_fetch_unit: RTL and testbench

- Fetch stage between the asynchronous 35-bit program ROM and the CPU execute stage.
- Owns the program counter and drives the ROM address; latches the returned word into an instruction register.
- Splits the word into decoded fields and hands it to execute over a valid/ready handshake.
- Redirects the PC when execute resolves a taken jump (JMP unconditional/EQ, ATC).

---
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage between the asynchronous program ROM and execute.
// It owns the PC, latches each ROM word into an instruction register, exposes
// the decoded fields and hands the word to execute over a valid/ready
// handshake. A taken branch on transfer redirects the PC and costs one bubble.
module instr_fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'd0,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   output logic [7:0]       rom_addr,
   input  logic [34:0]      rom_data,
   output logic             instr_valid,
   input  logic             exec_ready,
   output logic [34:0]      instr,
   output logic [7:0]       instr_pc,
   output logic [3:0]       opcode,
   output logic [2:0]       subop,
   output logic [1:0]       src1_type,
   output logic [7:0]       src1_val,
   output logic [1:0]       src2_type,
   output logic [7:0]       src2_val,
   output logic [7:0]       tgt_addr,
   input  logic             branch_taken,
   input  logic [7:0]       branch_addr,
   output logic [CNT_W-1:0] retired_cnt
);

   typedef enum logic {
      LOAD,
      RUN
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [7:0]       pc;
   logic [7:0]       pc_next;
   logic [34:0]      instr_next;
   logic [7:0]       instr_pc_next;
   logic             valid_next;
   logic [CNT_W-1:0] cnt_next;
   logic             transfer;

   assign rom_addr  = pc;
   assign transfer  = instr_valid & exec_ready;

   assign opcode    = instr[34:31];
   assign subop     = instr[30:28];
   assign src1_type = instr[27:26];
   assign src1_val  = instr[25:18];
   assign src2_type = instr[17:16];
   assign src2_val  = instr[15:8];
   assign tgt_addr  = instr[7:0];

   // Next-state logic: LOAD refills the empty register, RUN refills on each
   // transfer unless execute redirects, in which case the register empties.
   always_comb begin
      state_next    = state;
      pc_next       = pc;
      instr_next    = instr;
      instr_pc_next = instr_pc;
      valid_next    = instr_valid;
      cnt_next      = retired_cnt;

      unique case (state)
         LOAD: begin
            instr_next    = rom_data;
            instr_pc_next = pc;
            pc_next       = pc + 8'd1;
            valid_next    = 1'b1;
            state_next    = RUN;
         end
         RUN: begin
            if (transfer) begin
               if (branch_taken) begin
                  pc_next    = branch_addr;
                  valid_next = 1'b0;
                  state_next = LOAD;
               end else begin
                  instr_next    = rom_data;
                  instr_pc_next = pc;
                  pc_next       = pc + 8'd1;
                  valid_next    = 1'b1;
               end
            end
         end
         default: begin
            state_next = LOAD;
            valid_next = 1'b0;
         end
      endcase

      if (transfer && (retired_cnt != {CNT_W{1'b1}})) begin
         cnt_next = retired_cnt + CNT_W'(1);
      end
   end

   // State and datapath registers; reset wins over everything, even a stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= LOAD;
         pc          <= RESET_PC;
         instr       <= 35'b0;
         instr_pc    <= 8'd0;
         instr_valid <= 1'b0;
         retired_cnt <= '0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         instr       <= instr_next;
         instr_pc    <= instr_pc_next;
         instr_valid <= valid_next;
         retired_cnt <= cnt_next;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a ROM model feeds the fetch unit, expected fetch
// addresses are queued as the stimulus is scripted and popped on each transfer.
module tb_instr_fetch_unit;

   localparam int TB_CNT_W = 4;

   logic                clk;
   logic                reset;
   logic [7:0]          rom_addr;
   logic [34:0]         rom_data;
   logic                instr_valid;
   logic                exec_ready;
   logic [34:0]         instr;
   logic [7:0]          instr_pc;
   logic [3:0]          opcode;
   logic [2:0]          subop;
   logic [1:0]          src1_type;
   logic [7:0]          src1_val;
   logic [1:0]          src2_type;
   logic [7:0]          src2_val;
   logic [7:0]          tgt_addr;
   logic                branch_taken;
   logic [7:0]          branch_addr;
   logic [TB_CNT_W-1:0] retired_cnt;

   int                  check_count = 0;
   int                  pass_count  = 0;
   logic [7:0]          exp_q[$];
   logic [TB_CNT_W-1:0] exp_cnt = '0;
   logic                mon_on  = 1'b0;

   instr_fetch_unit #(
      .RESET_PC(8'd0),
      .CNT_W   (TB_CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .instr_valid (instr_valid),
      .exec_ready  (exec_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .opcode      (opcode),
      .subop       (subop),
      .src1_type   (src1_type),
      .src1_val    (src1_val),
      .src2_type   (src2_type),
      .src2_val    (src2_val),
      .tgt_addr    (tgt_addr),
      .branch_taken(branch_taken),
      .branch_addr (branch_addr),
      .retired_cnt (retired_cnt)
   );

   // ROM contents: address 7 is a JMP to 110, 0xF0..0xFF are unpopulated.
   function automatic logic [34:0] romWord(input logic [7:0] a);
      logic [34:0] w;
      if (a >= 8'hF0) begin
         w = 35'b0;
      end else if (a == 8'd7) begin
         w = {4'hA, 3'b001, 2'b01, 8'd0, 2'b01, 8'd0, 8'd110};
      end else begin
         w = {a[3:0], a[6:4], a[1:0], a, a[7:6], ~a, a ^ 8'h5A};
      end
      return w;
   endfunction

   assign rom_data = romWord(rom_addr);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [34:0] observed,
                              input logic [34:0] expected);
      check_count++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed,
                  expected, $time);
      end else begin
         pass_count++;
      end
   endtask

   // Inputs change just after the rising edge and hold through the next one.
   task automatic applyStimulus(input logic rst, input logic rdy,
                                input logic br, input logic [7:0] baddr);
      @(posedge clk);
      #1;
      reset        = rst;
      exec_ready   = rdy;
      branch_taken = br;
      branch_addr  = baddr;
   endtask

   // Scoreboard: every transfer must present the next queued address and its
   // ROM word; the retired counter is tracked independently and saturates.
   always @(negedge clk) begin
      if (mon_on) begin
         checkOutput("retired_cnt", 35'(retired_cnt), 35'(exp_cnt));
         if (!reset && instr_valid && exec_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("extra_transfer", 35'(exp_q.size()), 35'd1);
            end else begin
               logic [7:0]  ea;
               logic [34:0] ew;
               ea = exp_q.pop_front();
               ew = romWord(ea);
               checkOutput("instr_pc", 35'(instr_pc), 35'(ea));
               checkOutput("instr", instr, ew);
               checkOutput("opcode", 35'(opcode), 35'(ew[34:31]));
               checkOutput("subop", 35'(subop), 35'(ew[30:28]));
               checkOutput("src1_type", 35'(src1_type), 35'(ew[27:26]));
               checkOutput("src1_val", 35'(src1_val), 35'(ew[25:18]));
               checkOutput("src2_type", 35'(src2_type), 35'(ew[17:16]));
               checkOutput("src2_val", 35'(src2_val), 35'(ew[15:8]));
               checkOutput("tgt_addr", 35'(tgt_addr), 35'(ew[7:0]));
            end
         end
         if (reset) begin
            exp_cnt <= '0;
         end else if (instr_valid && exec_ready && (exp_cnt != {TB_CNT_W{1'b1}})) begin
            exp_cnt <= exp_cnt + 1'b1;
         end
      end
   end

   initial begin
      reset        = 1'b1;
      exec_ready   = 1'b0;
      branch_taken = 1'b0;
      branch_addr  = 8'd0;

      // Reset held for three edges.
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("reset_rom_addr", 35'(rom_addr), 35'd0);
      checkOutput("reset_valid", 35'(instr_valid), 35'd0);
      checkOutput("reset_cnt", 35'(retired_cnt), 35'd0);

      mon_on = 1'b1;
      for (int a = 0; a <= 5; a++) exp_q.push_back(8'(a));
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("first_pc", 35'(instr_pc), 35'd0);
      checkOutput("first_valid", 35'(instr_valid), 35'd1);
      repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);

      // Four stall cycles at address 5; a branch raised mid-stall is ignored.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, (i >= 2), 8'd200);
         @(negedge clk);
         checkOutput("stall_pc", 35'(instr_pc), 35'd5);
         checkOutput("stall_instr", instr, romWord(8'd5));
         checkOutput("stall_rom_addr", 35'(rom_addr), 35'd6);
         checkOutput("stall_valid", 35'(instr_valid), 35'd1);
         checkOutput("stall_cnt", 35'(retired_cnt), 35'd5);
      end

      // Redirect from the jump word at 7 to 110; address 8 must never appear.
      exp_q.push_back(8'd6);
      exp_q.push_back(8'd7);
      exp_q.push_back(8'd110);
      exp_q.push_back(8'd111);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 8'd110);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("bubble_valid", 35'(instr_valid), 35'd0);
      checkOutput("bubble_rom_addr", 35'(rom_addr), 35'd110);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("target_pc", 35'(instr_pc), 35'd110);
      checkOutput("target_valid", 35'(instr_valid), 35'd1);

      // Jump to 0xFF and wrap through 0x00, 0x01, 0x02, then jump to 38.
      applyStimulus(1'b0, 1'b1, 1'b1, 8'hFF);
      foreach (exp_q[i]) begin end
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'd38);
      exp_q.push_back(8'd39);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 8'd38);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);

      // Stall at 40 with the counter saturated, then reset mid-stall.
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("pre_reset_pc", 35'(instr_pc), 35'd40);
      checkOutput("saturated_cnt", 35'(retired_cnt), 35'd15);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("midstall_reset_valid", 35'(instr_valid), 35'd0);
      checkOutput("midstall_reset_rom_addr", 35'(rom_addr), 35'd0);
      checkOutput("midstall_reset_cnt", 35'(retired_cnt), 35'd0);

      exp_q.push_back(8'd0);
      exp_q.push_back(8'd1);
      exp_q.push_back(8'd2);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      checkOutput("final_pc", 35'(instr_pc), 35'd3);
      checkOutput("queue_drained", 35'(exp_q.size()), 35'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
